snake_head_stepper: RTL and testbench
=====================================

# snake_head_stepper

Downstream stage of the button/direction controller in the snake game. Consumes the 2-bit movement direction and pause flag, paces the game with a step timer, and advances the snake head one grid cell per step. Detects wall collisions and holds a game-over state until restarted. Head position and step pulse feed the body/render logic.

## Interface
- GRID_W, 32, playfield width in cells
- GRID_H, 24, playfield height in cells
- STEP_DIV, 2500000, clock cycles per step (≥2)
- START_X, 16, head x after reset/start
- START_Y, 12, head y after reset/start
- START_DIR, 3 (RIGHT), direction after reset/start
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- move_state  in  2  requested direction: UP=0, DOWN=1, LEFT=2, RIGHT=3
- is_paused  in  1  level; 1 freezes the game
- start  in  1  single-cycle pulse; begins or restarts a game
- head_x  out  $clog2(GRID_W)  head column, 0 = left
- head_y  out  $clog2(GRID_H)  head row, 0 = top
- dir_q  out  2  direction applied at the last step
- step_tick  out  1  one-cycle pulse when head moved
- running  out  1  1 in RUN or PAUSED
- game_over  out  1  1 in DEAD

## Operation
- States: IDLE, RUN, PAUSED, DEAD. Reset → IDLE.
- IDLE: head = (START_X, START_Y), dir_q = START_DIR, counter = 0. start → RUN.
- RUN: counter increments each cycle; at STEP_DIV-1 it wraps to 0 and a step occurs. is_paused=1 → PAUSED (counter held).
- PAUSED: counter and head frozen; is_paused=0 → RUN, counting resumes from the held value.
- Step: new direction = move_state, unless it is the exact opposite of dir_q (UP↔DOWN, LEFT↔RIGHT), in which case dir_q is kept. Next cell: UP y-1, DOWN y+1, LEFT x-1, RIGHT x+1.
- In-range next cell: head and dir_q update, step_tick=1.
- Out-of-range next cell (x<0, x≥GRID_W, y<0, y≥GRID_H): head and dir_q unchanged, no step_tick, → DEAD.
- DEAD: everything frozen. start → reload start position/dir, counter = 0, → RUN.
- start in RUN or PAUSED: ignored.
- start and is_paused both high in IDLE/DEAD: enter RUN; PAUSED on next cycle if is_paused still high.
- Boundary arithmetic uses one extra bit of width (or explicit edge compares); no silent modulo wrap.

## Timing
- Reset values: head_x=START_X, head_y=START_Y, dir_q=START_DIR, step_tick=0, running=0, game_over=0.
- All outputs registered. step_tick is high for exactly the cycle in which head_x/head_y first show the new cell.
- First step: STEP_DIV cycles after the start-sampling edge.
- move_state sampled only on the step edge; changes between steps have no effect.
- is_paused sampled every cycle; pause asserted on the step edge still takes effect before that step (pause has priority).
- game_over rises on the edge that would have produced the fatal step; running falls on the same edge.
- Asynchronous reset at any time forces IDLE and reset values immediately.

## Configuration
- SNAKE_WRAP_EN defined: leaving an edge wraps to the opposite edge (x: -1→GRID_W-1, GRID_W→0; same for y); walls never cause DEAD; step_tick pulses normally.
- Undefined: wall collision → DEAD as above.

## Structure
- Shared package snake_pkg: direction constants UP/DOWN/LEFT/RIGHT, 2-bit dir_t typedef, state enum, opposite-direction function. Used by the button controller as well.
- Sub-module step_timer: STEP_DIV counter with enable (RUN), synchronous clear (start), terminal-count pulse output.

## Test plan
- GRID_W=8, GRID_H=6, STEP_DIV=4, START (4,3), RIGHT; start, move_state=RIGHT → step_tick at cycles 4, 8, 12; head (5,3),(6,3),(7,3).
- Continue RIGHT from (7,3) → at cycle 16 no step_tick, game_over=1, running=0, head stays (7,3); with SNAKE_WRAP_EN head=(0,3), step_tick=1.
- From (4,3) RIGHT, set move_state=LEFT → reverse rejected, head (5,3), dir_q=RIGHT; then UP → (5,2), dir_q=UP.
- is_paused=1 for 10 cycles after counter=2 → no step_tick during pause; next step 2 cycles after release.
- DEAD, pulse start → head (4,3), dir_q=RIGHT, running=1; first step_tick 4 cycles later.
- Assert rst_n=0 mid-RUN between clock edges → outputs return to reset values without a clock edge.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game types: direction encoding, game state enum, opposite-direction helper.
// Used by the button/direction controller and the head stepper.
package snake_pkg;

    typedef logic [1:0] dir_t;

    localparam dir_t UP    = 2'd0;
    localparam dir_t DOWN  = 2'd1;
    localparam dir_t LEFT  = 2'd2;
    localparam dir_t RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        DEAD
    } state_t;

    // Opposite pairs differ only in bit 0 (UP/DOWN, LEFT/RIGHT).
    function automatic dir_t opposite(input dir_t d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/step_timer.sv
// Step pacing counter: counts 0..STEP_DIV-1 while enabled, synchronous clear,
// tick is high in the cycle whose edge wraps the count (i.e. the step edge).
module step_timer #(
    parameter int unsigned STEP_DIV = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = $clog2(STEP_DIV);

    logic [CW-1:0] count;

    assign tick = en && (count == CW'(STEP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tick ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: paces the game, advances the head one cell per step, detects walls.
// Define SNAKE_WRAP_EN to make the playfield wrap at its edges instead of killing the snake.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int unsigned GRID_W    = 32,
    parameter int unsigned GRID_H    = 24,
    parameter int unsigned STEP_DIV  = 2500000,
    parameter int unsigned START_X   = 16,
    parameter int unsigned START_Y   = 12,
    parameter dir_t        START_DIR = RIGHT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                move_state,
    input  logic                      is_paused,
    input  logic                      start,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic [1:0]                dir_q,
    output logic                      step_tick,
    output logic                      running,
    output logic                      game_over
);

    localparam int unsigned XW = $clog2(GRID_W);
    localparam int unsigned YW = $clog2(GRID_H);

    state_t        state;
    logic          timerEn;
    logic          timerClr;
    logic          stepDue;
    dir_t          newDir;
    logic [XW-1:0] nextX;
    logic [YW-1:0] nextY;
    logic          hitWall;

    // Pause wins over a coinciding step: the timer only advances when not paused.
    assign timerEn  = ((state == RUN) || (state == PAUSED)) && !is_paused;
    assign timerClr = start && ((state == IDLE) || (state == DEAD));

    step_timer #(
        .STEP_DIV(STEP_DIV)
    ) u_step_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (timerEn),
        .clr  (timerClr),
        .tick (stepDue)
    );

    // Candidate cell for the coming step; edge compares avoid any modulo wrap.
    always_comb begin
        newDir  = (move_state == opposite(dir_q)) ? dir_q : move_state;
        nextX   = head_x;
        nextY   = head_y;
        hitWall = 1'b0;
        unique case (newDir)
            UP: begin
                if (head_y == '0) begin
                    hitWall = 1'b1;
                    nextY   = YW'(GRID_H - 1);
                end else begin
                    nextY = head_y - YW'(1);
                end
            end
            DOWN: begin
                if (head_y == YW'(GRID_H - 1)) begin
                    hitWall = 1'b1;
                    nextY   = '0;
                end else begin
                    nextY = head_y + YW'(1);
                end
            end
            LEFT: begin
                if (head_x == '0) begin
                    hitWall = 1'b1;
                    nextX   = XW'(GRID_W - 1);
                end else begin
                    nextX = head_x - XW'(1);
                end
            end
            RIGHT: begin
                if (head_x == XW'(GRID_W - 1)) begin
                    hitWall = 1'b1;
                    nextX   = '0;
                end else begin
                    nextX = head_x + XW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            head_x    <= XW'(START_X);
            head_y    <= YW'(START_Y);
            dir_q     <= START_DIR;
            step_tick <= 1'b0;
            running   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            step_tick <= 1'b0;
            unique case (state)
                IDLE, DEAD: begin
                    if (start) begin
                        state     <= RUN;
                        head_x    <= XW'(START_X);
                        head_y    <= YW'(START_Y);
                        dir_q     <= START_DIR;
                        running   <= 1'b1;
                        game_over <= 1'b0;
                    end
                end
                RUN, PAUSED: begin
                    state <= is_paused ? PAUSED : RUN;
                    if (stepDue) begin
`ifdef SNAKE_WRAP_EN
                        head_x    <= nextX;
                        head_y    <= nextY;
                        dir_q     <= newDir;
                        step_tick <= 1'b1;
`else
                        if (hitWall) begin
                            state     <= DEAD;
                            running   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            head_x    <= nextX;
                            head_y    <= nextY;
                            dir_q     <= newDir;
                            step_tick <= 1'b1;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_head_stepper.sv
// Scoreboard bench for snake_head_stepper on an 8x6 grid with a 4-cycle step.
module tb_snake_head_stepper;
    import snake_pkg::*;

    typedef struct {
        int cyc;
        int x;
        int y;
        int dir;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] move_state;
    logic       is_paused;
    logic       start;
    logic [2:0] head_x;
    logic [2:0] head_y;
    logic [1:0] dir_q;
    logic       step_tick;
    logic       running;
    logic       game_over;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    snake_head_stepper #(
        .GRID_W   (8),
        .GRID_H   (6),
        .STEP_DIV (4),
        .START_X  (4),
        .START_Y  (3),
        .START_DIR(RIGHT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .move_state(move_state),
        .is_paused (is_paused),
        .start     (start),
        .head_x    (head_x),
        .head_y    (head_y),
        .dir_q     (dir_q),
        .step_tick (step_tick),
        .running   (running),
        .game_over (game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int got, input int expv);
        checks++;
        if (got != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    // Monitor: every step_tick must match the oldest expected step.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && step_tick === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tick: got tick at cycle %0d head (%0d,%0d) expected none",
                         cyc, head_x, head_y);
            end else begin
                e = q.pop_front();
                check("tick_cycle", cyc, e.cyc);
                check("tick_head_x", int'(head_x), e.x);
                check("tick_head_y", int'(head_y), e.y);
                check("tick_dir_q", int'(dir_q), e.dir);
            end
        end
    end

    task automatic waitCyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d pending steps expected 0 (next due cycle %0d)",
                     name, q.size(), q[0].cyc);
            q.delete();
        end
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_head_x"}, int'(head_x), 4);
        check({tag, "_head_y"}, int'(head_y), 3);
        check({tag, "_dir_q"}, int'(dir_q), 3);
        check({tag, "_step_tick"}, int'(step_tick), 0);
        check({tag, "_running"}, int'(running), 0);
        check({tag, "_game_over"}, int'(game_over), 0);
    endtask

    initial begin
        int s;
        move_state = RIGHT;
        is_paused  = 1'b0;
        start      = 1'b0;
        #1 rst_n = 1'b0;
        #1 checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_running", int'(running), 0);
        check("idle_head_x", int'(head_x), 4);

        // Run right into the east wall.
        pulseStart();
        s = cyc;
        check("start_running", int'(running), 1);
        check("start_game_over", int'(game_over), 0);
        q.push_back('{s + 4, 5, 3, 3});
        q.push_back('{s + 8, 6, 3, 3});
        q.push_back('{s + 12, 7, 3, 3});
`ifdef SNAKE_WRAP_EN
        q.push_back('{s + 16, 0, 3, 3});
`endif
        waitCyc(s + 16);
`ifdef SNAKE_WRAP_EN
        check("wrap_running", int'(running), 1);
        check("wrap_game_over", int'(game_over), 0);
`else
        check("wall_game_over", int'(game_over), 1);
        check("wall_running", int'(running), 0);
        check("wall_head_x", int'(head_x), 7);
        check("wall_head_y", int'(head_y), 3);
        check("wall_dir_q", int'(dir_q), 3);
`endif
        drain("drain_east");

`ifdef SNAKE_WRAP_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        // Restart, reverse rejection, turn, start-while-running, pause.
        pulseStart();
        s = cyc;
        check("restart_head_x", int'(head_x), 4);
        check("restart_head_y", int'(head_y), 3);
        check("restart_dir_q", int'(dir_q), 3);
        check("restart_running", int'(running), 1);
        check("restart_game_over", int'(game_over), 0);
        move_state = LEFT;
        q.push_back('{s + 4, 5, 3, 3});
        waitCyc(s + 4);
        move_state = UP;
        q.push_back('{s + 8, 5, 2, 0});
        waitCyc(s + 5);
        pulseStart();
        waitCyc(s + 10);
        is_paused = 1'b1;
        q.push_back('{s + 22, 5, 1, 0});
        waitCyc(s + 12);
        check("paused_running", int'(running), 1);
        check("paused_game_over", int'(game_over), 0);
        waitCyc(s + 20);
        is_paused = 1'b0;
        // Pause landing exactly on the step edge defers that step by one cycle.
        waitCyc(s + 25);
        is_paused = 1'b1;
        @(negedge clk);
        is_paused = 1'b0;
        q.push_back('{s + 27, 5, 0, 0});
`ifdef SNAKE_WRAP_EN
        q.push_back('{s + 31, 5, 5, 0});
`endif
        waitCyc(s + 31);
`ifdef SNAKE_WRAP_EN
        check("top_wrap_running", int'(running), 1);
`else
        check("top_game_over", int'(game_over), 1);
        check("top_running", int'(running), 0);
        check("top_head_y", int'(head_y), 0);
`endif
        drain("drain_turns");

`ifndef SNAKE_WRAP_EN
        pulseStart();
        s = cyc;
        q.push_back('{s + 4, 4, 2, 0});
        waitCyc(s + 5);
`endif
        // Asynchronous reset between edges while running.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 checkResetValues("async");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("post_reset_running", int'(running), 0);
        drain("drain_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish by 20000 expected finish");
        $fatal(1);
    end

endmodule
